// File: rtl/pe_pkg.sv
// Shared helpers for pe_mac_array: log2, default pipeline depth and result narrowing.
// Narrowing saturates when PE_MAC_SAT_EN is defined and wraps otherwise.
package pe_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int N_LANES_DEF = 8;
  localparam int TREE_LVLS   = clog2(N_LANES_DEF);
  localparam int LAT         = TREE_LVLS + 2;

  // Upper bounds so one function serves every DATA_W/ACC_W instance.
  localparam int MAX_DATA_W = 64;
  localparam int MAX_ACC_W  = 256;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] val;
    logic                  ovf;
  } narrow_t;

  // r arrives sign-extended to MAX_ACC_W; only the low data_w bits of val are meaningful.
  function automatic narrow_t sat_narrow(input logic [MAX_ACC_W-1:0] r, input int data_w);
    narrow_t res;
    logic    sign;
    res  = '0;
    sign = r[MAX_ACC_W-1];
    for (int i = 0; i < MAX_ACC_W; i++) begin
      if (i >= data_w - 1 && r[i] != sign) res.ovf = 1'b1;
    end
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < data_w) res.val[i] = r[i];
    end
`ifdef PE_MAC_SAT_EN
    if (res.ovf) begin
      for (int i = 0; i < MAX_DATA_W; i++) begin
        if (i < data_w - 1) res.val[i] = ~sign;
        else if (i == data_w - 1) res.val[i] = sign;
      end
    end
`endif
    return res;
  endfunction

endpackage

// File: rtl/pe_mac_array_adder_tree_pipe.sv
// Registered pairwise adder tree (one level per cycle) for pe_mac_array;
// valid/first/last/bias travel alongside each level.
module adder_tree_pipe
  import pe_pkg::*;
#(
  parameter int N_LANES = 8,
  parameter int IN_W    = 64,
  parameter int BIAS_W  = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_vld,
  input  logic                                 i_first,
  input  logic                                 i_last,
  input  logic [BIAS_W-1:0]                    i_bias,
  input  logic [N_LANES*IN_W-1:0]              i_data,
  output logic                                 o_vld,
  output logic                                 o_first,
  output logic                                 o_last,
  output logic [BIAS_W-1:0]                    o_bias,
  output logic [IN_W+clog2(N_LANES)-1:0]       o_sum,
  output logic                                 o_busy
);

  localparam int LVLS = clog2(N_LANES);

  logic [LVLS:0] busy_vec;

  genvar gi, gj;
  generate
    for (gi = 0; gi <= LVLS; gi++) begin : g_lvl
      localparam int W = IN_W + gi;
      localparam int N = N_LANES >> gi;

      logic signed [W-1:0] sum_q [N];
      logic                vld_q;
      logic                first_q;
      logic                last_q;
      logic [BIAS_W-1:0]   bias_q;

      if (gi == 0) begin : g_in
        // Level 0 is the already-registered product stage upstream.
        for (gj = 0; gj < N; gj++) begin : g_lane
          assign sum_q[gj] = i_data[gj*IN_W +: IN_W];
        end
        assign vld_q       = i_vld;
        assign first_q     = i_first;
        assign last_q      = i_last;
        assign bias_q      = i_bias;
        assign busy_vec[0] = 1'b0;
      end else begin : g_reg
        logic signed [W-1:0] sum_d [N];
        logic                vld_d;
        logic                first_d;
        logic                last_d;
        logic [BIAS_W-1:0]   bias_d;

        always_comb begin
          for (int j = 0; j < N; j++) begin
            sum_d[j] = W'(g_lvl[gi-1].sum_q[2*j]) + W'(g_lvl[gi-1].sum_q[2*j+1]);
          end
          vld_d   = g_lvl[gi-1].vld_q;
          first_d = g_lvl[gi-1].first_q;
          last_d  = g_lvl[gi-1].last_q;
          bias_d  = g_lvl[gi-1].bias_q;
        end

        always_ff @(posedge clk) begin
          if (!rst) vld_q <= 1'b0;
          else      vld_q <= vld_d;
        end

        always_ff @(posedge clk) begin
          sum_q   <= sum_d;
          first_q <= first_d;
          last_q  <= last_d;
          bias_q  <= bias_d;
        end

        assign busy_vec[gi] = vld_q;
      end
    end
  endgenerate

  assign o_sum   = g_lvl[LVLS].sum_q[0];
  assign o_vld   = g_lvl[LVLS].vld_q;
  assign o_first = g_lvl[LVLS].first_q;
  assign o_last  = g_lvl[LVLS].last_q;
  assign o_bias  = g_lvl[LVLS].bias_q;
  assign o_busy  = |busy_vec;

endmodule

// File: rtl/pe_mac_array.sv
// N_LANES signed multipliers -> pipelined adder tree -> bias-seeded accumulator.
// PE_MAC_SAT_EN selects saturating (defined) or wrapping (undefined) result narrowing.
module pe_mac_array
  import pe_pkg::*;
#(
  parameter int N_LANES   = 8,
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 0,
  parameter int ACC_W     = 2*DATA_W+8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_vld,
  input  logic                        i_first,
  input  logic                        i_last,
  input  logic [N_LANES*DATA_W-1:0]   i_a,
  input  logic [N_LANES*DATA_W-1:0]   i_b,
  input  logic [DATA_W-1:0]           bias_val,
  output logic [DATA_W-1:0]           o_res,
  output logic                        o_vld,
  output logic                        o_ovf,
  output logic                        o_busy
);

  localparam int LVLS   = clog2(N_LANES);
  localparam int PROD_W = 2*DATA_W;
  localparam int SUM_W  = PROD_W + LVLS;

  logic [N_LANES*PROD_W-1:0] prod_d, prod_q;
  logic                      m_vld_d, m_vld_q;
  logic                      m_first_d, m_first_q;
  logic                      m_last_d, m_last_q;
  logic [DATA_W-1:0]         m_bias_d, m_bias_q;

  always_comb begin
    prod_d = '0;
    for (int k = 0; k < N_LANES; k++) begin
      prod_d[k*PROD_W +: PROD_W] = PROD_W'($signed(i_a[k*DATA_W +: DATA_W]))
                                 * PROD_W'($signed(i_b[k*DATA_W +: DATA_W]));
    end
    m_vld_d   = i_vld;
    m_first_d = i_first;
    m_last_d  = i_last;
    m_bias_d  = bias_val;
  end

  always_ff @(posedge clk) begin
    if (!rst) m_vld_q <= 1'b0;
    else      m_vld_q <= m_vld_d;
  end

  always_ff @(posedge clk) begin
    prod_q    <= prod_d;
    m_first_q <= m_first_d;
    m_last_q  <= m_last_d;
    m_bias_q  <= m_bias_d;
  end

  logic              t_vld, t_first, t_last, t_busy;
  logic [DATA_W-1:0] t_bias;
  logic [SUM_W-1:0]  t_sum;

  adder_tree_pipe #(
    .N_LANES (N_LANES),
    .IN_W    (PROD_W),
    .BIAS_W  (DATA_W)
  ) u_tree (
    .clk     (clk),
    .rst     (rst),
    .i_vld   (m_vld_q),
    .i_first (m_first_q),
    .i_last  (m_last_q),
    .i_bias  (m_bias_q),
    .i_data  (prod_q),
    .o_vld   (t_vld),
    .o_first (t_first),
    .o_last  (t_last),
    .o_bias  (t_bias),
    .o_sum   (t_sum),
    .o_busy  (t_busy)
  );

  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic signed [ACC_W-1:0] seed, acc_sum, r_s;
  narrow_t                 nar;
  logic [DATA_W-1:0]       o_res_d, o_res_q;
  logic                    o_vld_d, o_vld_q;
  logic                    o_ovf_d, o_ovf_q;

  // The result is taken from the updated sum, so output and accumulator register together.
  always_comb begin
    seed    = t_first ? (ACC_W'($signed(t_bias)) <<< FRAC_BITS) : acc_q;
    acc_sum = seed + ACC_W'($signed(t_sum));
    r_s     = acc_sum >>> FRAC_BITS;
    nar     = sat_narrow(MAX_ACC_W'(r_s), DATA_W);
    acc_d   = acc_q;
    o_res_d = o_res_q;
    o_vld_d = 1'b0;
    o_ovf_d = 1'b0;
    if (t_vld) begin
      acc_d = t_last ? '0 : acc_sum;
      if (t_last) begin
        o_vld_d = 1'b1;
        o_ovf_d = nar.ovf;
        o_res_d = DATA_W'(nar.val);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q   <= '0;
      o_res_q <= '0;
      o_vld_q <= 1'b0;
      o_ovf_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      o_res_q <= o_res_d;
      o_vld_q <= o_vld_d;
      o_ovf_q <= o_ovf_d;
    end
  end

  assign o_res  = o_res_q;
  assign o_vld  = o_vld_q;
  assign o_ovf  = o_ovf_q;
  assign o_busy = m_vld_q | t_busy;

endmodule

// File: doc/pe_mac_array.md
Name: pe_mac_array

Overview:
- Parametrised successor of the fixed 4-pair processing element: N_LANES signed fixed-point multipliers feed a pipelined adder tree into a bias-seeded accumulator.
- Computes multi-beat dot products (one neuron output per i_first..i_last burst) for the inference datapath.
- Adds over the previous generation: generic lane count and width, first/last framing, Q-format scaling, overflow reporting.

Parameters:
- N_LANES, 8, multiplier lanes per beat; power of 2, at least 2.
- DATA_W, 32, operand, bias and result width; signed two's complement.
- FRAC_BITS, 0, fractional bits of the Q format; must be less than DATA_W.
- ACC_W, 2*DATA_W+8, internal accumulator width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low; rst=0 resets on the rising edge of clk.
- i_vld  in  1  beat valid; no backpressure, so every valid beat is consumed.
- i_first  in  1  first beat of a dot product; the accumulator is seeded with bias_val.
- i_last  in  1  last beat; the result is emitted for this beat.
- i_a  in  N_LANES*DATA_W  packed operands; lane k is bits [k*DATA_W +: DATA_W].
- i_b  in  N_LANES*DATA_W  packed operands, same packing.
- bias_val  in  DATA_W  Q-format bias, sampled on a beat with i_first=1.
- o_res  out  DATA_W  Q-format dot-product result.
- o_vld  out  1  one-cycle pulse qualifying o_res and o_ovf.
- o_ovf  out  1  narrowing overflow on this result.
- o_busy  out  1  at least one valid beat is in the pipeline.

Behaviour:
- Reset (rst=0): all stage valids, accumulator, o_res, o_vld, o_ovf and o_busy cleared to 0. A reset mid-burst discards in-flight beats, and no o_vld is produced for them.
- Stage M (1 cycle): registers the 2*DATA_W signed product of each lane. i_vld, i_first, i_last and bias_val are pipelined alongside the data.
- Stage T (log2(N_LANES) cycles): registered pairwise adder tree. Each level grows by 1 bit, and the final sum is sign-extended to ACC_W.
- Stage A (1 cycle), on a valid beat: acc <= (first ? sext(bias_val)<<FRAC_BITS : acc) + tree_sum.
- ACC_W arithmetic wraps silently.
- Output: on a valid beat with last=1, compute r = acc >>> FRAC_BITS (arithmetic shift), narrow r to DATA_W, and register o_res with o_vld=1.
- Latency: o_vld occurs log2(N_LANES)+2 cycles after the i_last beat (5 for N_LANES=8).
- After emitting, acc clears to 0. A later beat without i_first therefore starts from 0 (zero bias).
- i_first and i_last together on one beat form a single-beat dot product.
- An i_first beat arriving mid-burst (no preceding last) abandons the old sum silently.
- Idle cycles (i_vld=0) between beats are allowed and do not change acc.
- Full throughput: one beat per cycle, and back-to-back bursts need no bubble.
- o_ovf=1 when r lies outside [-2^(DATA_W-1), 2^(DATA_W-1)-1]. It is valid only with o_vld and is 0 otherwise.
- o_busy = OR of all stage valids.

Optional Feature:
- Macro: PE_MAC_SAT_EN.
- Defined: an out-of-range r clamps to 2^(DATA_W-1)-1 (positive) or -2^(DATA_W-1) (negative).
- Undefined: o_res = r[DATA_W-1:0] (wrap).
- o_ovf reports overflow identically in both builds.

Decomposition:
- Package pe_pkg holds:
  - clog2 function;
  - derived localparams TREE_LVLS = clog2(N_LANES) and LAT = TREE_LVLS+2;
  - sat_narrow function (ACC_W to DATA_W, returning value and overflow).
- Sub-module adder_tree_pipe (parameters N_LANES and IN_W): registered tree that carries valid/first/last/bias sideband through its levels.

Test Plan:
- Single-beat sum: N_LANES=8, FRAC_BITS=0; first=last=1, a=1..8, b=2 on all lanes, bias=10 -> o_res=82 exactly 5 cycles later, o_ovf=0.
- Multi-beat framing: 3 back-to-back beats with all lanes a=1, b=1, bias=0, then an immediate second single-beat burst (all lanes 1x1, bias=0) -> o_res=24, then o_res=8 one cycle later.
- Signed and idle gaps: 2 beats separated by 3 idle cycles, a=-3, b=5 on all lanes, bias=-1 -> o_res=-241.
- Q format: FRAC_BITS=16, one lane 1.5 (0x18000) x 2.0 (0x20000), other lanes 0, bias=0.25 (0x4000) -> o_res=0x34000.
- Overflow: all lanes a=b=0x7FFFFFFF, single beat -> o_ovf=1; o_res=0x7FFFFFFF with PE_MAC_SAT_EN, else the low 32 bits of the shifted sum (0x00000008).
- Reset mid-operation: rst=0 for 1 cycle, 2 cycles after an i_last beat -> no o_vld, o_busy=0; the next burst's result is uncorrupted.
